mem_bist_master: RTL and testbench

Memory built-in self-test master that drives the single-port 16-bit valid/ready SRAM interface (addr, wdata, wr_rd, valid, ready, rdata). On a start pulse it writes a deterministic pattern over a programmed address range, reads the range back, compares each word, and reports pass/fail, the error count and the first failing location. It sits directly upstream of the SRAM block and owns its request port for the duration of a test.

---
 rtl/mem_bist_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_bist_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes pattern^addr over a programmed range of a valid/ready SRAM,
// reads it back, and reports pass/fail, mismatch count and the first failing word.
module mem_bist_master #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  input  logic [WIDTH-1:0]      pattern_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_rd_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  cfg_err_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [WIDTH-1:0]      fail_data_o,
  output logic [2:0]            dbg_state_o
);

  // Handshake: mem_valid_o is a one-cycle request pulse; the SRAM answers with a
  // one-cycle mem_ready_i some cycles later (read data valid with it). No new request
  // is issued until that ready has been sampled.

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [WIDTH-1:0]      pattern_q, pattern_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  wr_rd_q, wr_rd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0]      fail_data_q, fail_data_d;

  logic wait_expired;
  logic last_addr;

  function automatic logic [WIDTH-1:0] word_of(input logic [WIDTH-1:0]      seed,
                                               input logic [ADDR_WIDTH-1:0] a);
    return seed ^ WIDTH'(a);
  endfunction

  assign wait_expired = (timer_q == TW'(TIMEOUT - 1));
  assign last_addr    = (addr_q == end_q);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    pattern_d   = pattern_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_rd_d     = wr_rd_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    cfg_err_d   = cfg_err_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    unique case (state_q)
      IDLE: begin
        // done_q still high means this is the completion cycle; a start here is dropped
        if (start_i && !done_q) begin
          start_d     = start_addr_i;
          end_d       = end_addr_i;
          pattern_d   = pattern_i;
          err_count_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          cfg_err_d   = 1'b0;
          if (start_addr_i > end_addr_i) begin
            cfg_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            busy_d  = 1'b1;
            addr_d  = start_addr_i;
            wdata_d = word_of(pattern_i, start_addr_i);
            wr_rd_d = 1'b1;
            valid_d = 1'b1;
            state_d = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        timer_d = '0;
        state_d = WR_WAIT;
      end

      WR_WAIT: begin
        if (mem_ready_i) begin
          valid_d = 1'b1;
          if (last_addr) begin
            addr_d  = start_q;
            wr_rd_d = 1'b0;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr_q + 1'b1;
            wdata_d = word_of(pattern_q, addr_q + 1'b1);
            state_d = WR_REQ;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RD_REQ: begin
        timer_d = '0;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (mem_ready_i) begin
          if (mem_rdata_i != word_of(pattern_q, addr_q)) begin
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) begin
              fail_addr_d = addr_q;
              fail_data_d = mem_rdata_i;
            end
          end
          if (last_addr) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            valid_d = 1'b1;
            state_d = RD_REQ;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count_q == '0) && !timeout_q && !cfg_err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      pattern_q   <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_rd_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      pattern_q   <= pattern_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_rd_q     <= wr_rd_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cfg_err_q   <= cfg_err_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wr_rd_o = wr_rd_q;
  assign mem_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign cfg_err_o   = cfg_err_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_count_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: SRAM model with fault/stall injection, request and
// result scoreboards fed by a range-level reference model.
module tb_mem_bist_master;
  localparam int WIDTH    = 16;
  localparam int AW       = 10;
  localparam int TIMEOUT  = 15;
  localparam int REQ_W    = 1 + AW + WIDTH;
  localparam int RES_W    = 4 + (AW + 1) + AW + WIDTH;
  localparam int NO_STALL = 1 << 30;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [AW-1:0]    start_addr_i, end_addr_i;
  logic [WIDTH-1:0] pattern_i;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             mem_wr_rd_o, mem_valid_o, mem_ready_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             busy_o, done_o, pass_o, cfg_err_o, timeout_o;
  logic [AW:0]      err_count_o;
  logic [AW-1:0]    fail_addr_o;
  logic [WIDTH-1:0] fail_data_o;
  logic [2:0]       dbg_state_o;

  mem_bist_master #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .pattern_i(pattern_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wr_rd_o(mem_wr_rd_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .cfg_err_o(cfg_err_o),
    .timeout_o(timeout_o), .err_count_o(err_count_o), .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [REQ_W-1:0] exp_req_q[$];
  logic [RES_W-1:0] exp_res_q[$];

  // SRAM model configuration
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  int               max_lat = 0;
  int               stall_idx = NO_STALL;
  int               acc_cnt = 0;
  bit               flip_en = 0;
  int               flip_a = 0;
  bit               stuck_en = 0;
  int               stuck_a = 0;
  int               stuck_b = 0;
  bit               pend = 0;
  int               cnt = 0;
  logic [WIDTH-1:0] rd_hold = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] faulty(input logic [WIDTH-1:0] d, input int a);
    logic [WIDTH-1:0] r;
    r = d;
    if (flip_en && a == flip_a) r[0] = ~r[0];
    if (stuck_en && a == stuck_a) r[stuck_b] = 1'b0;
    return r;
  endfunction

  // SRAM: sees a request at the negedge, answers ready 1+lat negedges later
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      mem_ready_i = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = rd_hold;
          pend = 0;
        end else cnt--;
      end
      if (rst_i === 1'b1 && mem_valid_o === 1'b1) begin
        pend = 1;
        cnt = $urandom_range(0, max_lat);
        if (acc_cnt == stall_idx) cnt = NO_STALL;
        acc_cnt++;
        if (mem_wr_rd_o) mem[mem_addr_o] = mem_wdata_o;
        else rd_hold = faulty(mem[mem_addr_o], int'(mem_addr_o));
      end
    end
  end

  // monitor: pops an expectation whenever the DUT issues a request or completes
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i === 1'b1 && mem_valid_o === 1'b1) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request actual=%0h required=none", {mem_wr_rd_o, mem_addr_o});
        end else begin
          check("mem_request",
                128'({mem_wr_rd_o, mem_addr_o, mem_wr_rd_o ? mem_wdata_o : WIDTH'(0)}),
                128'(exp_req_q.pop_front()));
        end
      end
      if (rst_i === 1'b1 && done_o === 1'b1) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          check("result",
                128'({busy_o, pass_o, cfg_err_o, timeout_o, err_count_o, fail_addr_o, fail_data_o}),
                128'(exp_res_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({mem_addr_o, mem_wdata_o, mem_wr_rd_o, mem_valid_o, busy_o, done_o, pass_o,
                 cfg_err_o, timeout_o, err_count_o, fail_addr_o, fail_data_o, dbg_state_o});
  endfunction

  // reference model: request sequence and final report for one test
  task automatic model_push(input int s, input int e, input logic [WIDTH-1:0] pat, input int stall);
    int n, total, errs, fa, a;
    bit to;
    logic [WIDTH-1:0] good, rd, fd;
    logic [AW:0] ec;
    errs = 0; fa = 0; fd = '0;
    if (s > e) begin
      exp_res_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, (AW+1)'(0), AW'(0), WIDTH'(0)});
      return;
    end
    n = e - s + 1;
    to = (stall < 2 * n);
    total = to ? stall + 1 : 2 * n;
    for (int i = 0; i < total; i++) begin
      a = (i < n) ? s + i : s + i - n;
      good = pat ^ WIDTH'(a);
      if (i < n) exp_req_q.push_back({1'b1, AW'(a), good});
      else begin
        exp_req_q.push_back({1'b0, AW'(a), WIDTH'(0)});
        if (i != stall) begin
          rd = faulty(good, a);
          if (rd != good) begin
            if (errs == 0) begin fa = a; fd = rd; end
            errs++;
          end
        end
      end
    end
    ec = (errs > (1 << (AW + 1)) - 1) ? '1 : (AW+1)'(errs);
    exp_res_q.push_back({1'b0, (errs == 0) && !to, 1'b0, to, ec, AW'(fa), fd});
  endtask

  // driver tasks
  task automatic run_test(input int s, input int e, input logic [WIDTH-1:0] pat, input int stall,
                          input bit fl, input int fl_a, input bit st, input int st_a, input int st_b,
                          input int lat, input bit poke, input bit start_in_done);
    int n, k, budget, exp_k;
    max_lat = lat; stall_idx = stall; acc_cnt = 0; pend = 0;
    flip_en = fl; flip_a = fl_a; stuck_en = st; stuck_a = st_a; stuck_b = st_b;
    n = (s <= e) ? e - s + 1 : 0;
    model_push(s, e, pat, stall);
    @(negedge clk);
    start_i = 1'b1; start_addr_i = AW'(s); end_addr_i = AW'(e); pattern_i = pat;
    @(negedge clk);
    start_i = 1'b0;
    if (s <= e) check("busy_start", 128'(busy_o), 128'(1));
    budget = 8 * (n + 1) * (lat + 2) + 64;
    k = 1;
    while (done_o !== 1'b1 && k < budget) begin
      if (poke && k == 5) begin
        start_i = 1'b1; start_addr_i = '0; end_addr_i = '1; pattern_i = ~pat;
      end else start_i = 1'b0;
      @(negedge clk);
      k++;
    end
    start_i = 1'b0;
    if (done_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_wait actual=no_done required=done within %0d cycles", budget);
      exp_req_q.delete(); exp_res_q.delete();
      return;
    end
    if (lat == 0) begin
      exp_k = (s > e) ? 2 : (stall < 2 * n) ? 2 * stall + 18 : 4 * n + 2;
      check("done_latency", 128'(k), 128'(exp_k));
    end
    if (start_in_done) begin
      start_i = 1'b1; start_addr_i = '0; end_addr_i = AW'(3); pattern_i = pat;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      check("start_in_done_ignored", 128'(busy_o), 128'(0));
    end else @(negedge clk);
    check("requests_drained", 128'(exp_req_q.size()), 128'(0));
    check("result_drained", 128'(exp_res_q.size()), 128'(0));
    exp_req_q.delete(); exp_res_q.delete();
  endtask

  task automatic mid_reset_test();
    int k;
    max_lat = 0; stall_idx = NO_STALL; acc_cnt = 0; pend = 0;
    flip_en = 0; stuck_en = 0;
    model_push(0, 7, 16'h1234, NO_STALL);
    @(negedge clk);
    start_i = 1'b1; start_addr_i = '0; end_addr_i = AW'(7); pattern_i = 16'h1234;
    @(negedge clk);
    start_i = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (mem_valid_o === 1'b1 && mem_wr_rd_o === 1'b0 && mem_addr_o == AW'(2)) break;
      @(negedge clk);
    end
    check("reach_read_2", 128'(k < 200), 128'(1));
    @(negedge clk);
    #2 rst_i = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 128'(0));
    exp_req_q.delete(); exp_res_q.delete();
    pend = 0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int s, e, n, stall, lat;
    logic [WIDTH-1:0] pat;
    rst_i = 1'b0; start_i = 1'b0; start_addr_i = '0; end_addr_i = '0; pattern_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 128'(0));
    rst_i = 1'b1;
    @(negedge clk);

    run_test(0, 3, 16'hA5A5, NO_STALL, 0, 0, 0, 0, 0, 0, 0, 1);
    run_test(0, 3, 16'hA5A5, NO_STALL, 1, 2, 0, 0, 0, 0, 0, 0);
    run_test(5, 4, 16'hA5A5, NO_STALL, 0, 0, 0, 0, 0, 0, 0, 0);
    run_test(0, 3, 16'hA5A5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_test(0, 1023, 16'hFFFF, NO_STALL, 0, 0, 1, 1023, 15, 0, 0, 0);
    mid_reset_test();
    run_test(0, 7, 16'h1234, NO_STALL, 0, 0, 0, 0, 0, 0, 0, 0);
    run_test(1020, 1023, 16'h0F0F, 6, 1, 1021, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      s = $urandom_range(0, 1023);
      e = s + $urandom_range(0, 24);
      if (e > 1023) e = 1023;
      if ($urandom_range(0, 7) == 0) begin
        if (s == 0) s = 1;
        e = $urandom_range(0, s - 1);
      end
      n = (s <= e) ? e - s + 1 : 0;
      stall = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, 2 * n - 1) : NO_STALL;
      lat = $urandom_range(0, 3);
      pat = WIDTH'($urandom);
      run_test(s, e, pat, stall,
               $urandom_range(0, 1) == 1, s + $urandom_range(0, n),
               $urandom_range(0, 1) == 1, s + $urandom_range(0, n), $urandom_range(0, WIDTH - 1),
               lat, t == 3, t == 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
